// File: rtl/fpu_pkg.sv
// FPU result word layout, status codes and occupancy states
// shared by the result queue, its interface and the decoder.
package fpu_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int WORD_W = SIGN_W + EXP_W + MANT_W;
  localparam int STAT_W = 4;
  localparam int UEXP_W = EXP_W + 1;
  localparam int BIAS   = 31;

  localparam logic [STAT_W-1:0] EXACT     = 4'b0001;
  localparam logic [STAT_W-1:0] INEXACT   = 4'b1111;
  localparam logic [STAT_W-1:0] OVERFLOW  = 4'b0011;
  localparam logic [STAT_W-1:0] UNDERFLOW = 4'b0111;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fpu_word_t;

  function automatic logic [UEXP_W-1:0] unbias(
    input logic [EXP_W-1:0] e
  );
    return {1'b0, e} - UEXP_W'(BIAS);
  endfunction

endpackage

// File: rtl/fpu_result_queue_if.sv
// Producer/consumer bundle of the FPU result queue.
// The slave side is the queue, the master side drives it.
interface fpu_result_queue_if;
  import fpu_pkg::*;

  logic [WORD_W-1:0] res_data_in;
  logic [STAT_W-1:0] res_status_in;
  logic              res_valid_in;
  logic              ready_in;
  logic              valid_out;
  logic [WORD_W-1:0] data_out;
  logic [STAT_W-1:0] status_out;
  logic              sign_out;
  logic [UEXP_W-1:0] exp_out;
  logic              zero_out;

  modport master (
    output res_data_in,
    output res_status_in,
    output res_valid_in,
    output ready_in,
    input  valid_out,
    input  data_out,
    input  status_out,
    input  sign_out,
    input  exp_out,
    input  zero_out
  );

  modport slave (
    input  res_data_in,
    input  res_status_in,
    input  res_valid_in,
    input  ready_in,
    output valid_out,
    output data_out,
    output status_out,
    output sign_out,
    output exp_out,
    output zero_out
  );

endinterface

// File: rtl/fpu_result_decode.sv
// Splits an FPU result word into sign, unbiased exponent
// and zero flag; all fields read 0 when the word is not valid.
module fpu_result_decode
  import fpu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic              valid,
  output logic              sign,
  output logic [UEXP_W-1:0] exp_u,
  output logic              zero
);

  fpu_word_t w;

  assign w = word;

  // gated field decode of the head word
  always_comb begin
    sign  = 1'b0;
    exp_u = '0;
    zero  = 1'b0;
    if (valid) begin
      sign  = w.sign;
      exp_u = unbias(w.exp);
      zero  = (w.exp == '0) && (w.mant == '0);
    end
  end

endmodule

// File: rtl/fpu_result_queue.sv
// First-word-fall-through FPU result queue with per-status
// saturating counters and a sticky overflow-drop flag.
module fpu_result_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_in,
  fpu_result_queue_if.slave q,
  output logic [CNT_W-1:0] cnt_exact,
  output logic [CNT_W-1:0] cnt_inexact,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic [CNT_W-1:0] cnt_unf,
  output logic             drop_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WORD_W-1:0] mem_data [DEPTH];
  logic [STAT_W-1:0] mem_stat [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  occ_e              occ;
  logic              valid;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] head_data;
  logic [STAT_W-1:0] head_stat;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // occupancy state from the entry count
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)
      occ = OCC_EMPTY;
    else if (count == OCC_W'(DEPTH))
      occ = OCC_FULL;
  end

  assign valid = (occ != OCC_EMPTY);
  assign pop   = valid & q.ready_in;
  assign push  = q.res_valid_in
               & ((occ != OCC_FULL) | pop);

  // pointers and count; pointers wrap at DEPTH
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // entry storage, written on accepted pushes only
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_data[wr_ptr] <= q.res_data_in;
      mem_stat[wr_ptr] <= q.res_status_in;
    end
  end

  assign head_data = valid ? mem_data[rd_ptr] : '0;
  assign head_stat = valid ? mem_stat[rd_ptr] : '0;

  assign q.valid_out  = valid;
  assign q.data_out   = head_data;
  assign q.status_out = head_stat;

  fpu_result_decode u_dec (
    .word  (head_data),
    .valid (valid),
    .sign  (q.sign_out),
    .exp_u (q.exp_out),
    .zero  (q.zero_out)
  );

  // per-status counters; every strobe counts, clear wins
  always_ff @(posedge clock) begin
    if (reset || clear_in) begin
      cnt_exact   <= '0;
      cnt_inexact <= '0;
      cnt_ovf     <= '0;
      cnt_unf     <= '0;
    end else if (q.res_valid_in) begin
      case (q.res_status_in)
        EXACT:     cnt_exact   <= sat_inc(cnt_exact);
        INEXACT:   cnt_inexact <= sat_inc(cnt_inexact);
        OVERFLOW:  cnt_ovf     <= sat_inc(cnt_ovf);
        UNDERFLOW: cnt_unf     <= sat_inc(cnt_unf);
        default:   ;
      endcase
    end
  end

  // sticky flag for results lost to a full queue
  always_ff @(posedge clock) begin
    if (reset || clear_in)
      drop_out <= 1'b0;
    else if (q.res_valid_in && occ == OCC_FULL && !pop)
      drop_out <= 1'b1;
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Bench for fpu_result_queue: decode vector table, scoreboard
// for queue order, and a counter/drop-flag reference model.
module tb_fpu_result_queue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset;
  logic clear_in;
  logic [CNT_W-1:0] cnt_exact;
  logic [CNT_W-1:0] cnt_inexact;
  logic [CNT_W-1:0] cnt_ovf;
  logic [CNT_W-1:0] cnt_unf;
  logic drop_out;

  always #5 clock = ~clock;

  fpu_result_queue_if bus ();

  fpu_result_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear_in    (clear_in),
    .q           (bus),
    .cnt_exact   (cnt_exact),
    .cnt_inexact (cnt_inexact),
    .cnt_ovf     (cnt_ovf),
    .cnt_unf     (cnt_unf),
    .drop_out    (drop_out)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  stat;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  stat;
    logic        sgn;
    logic [6:0]  ex;
    logic        zr;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  ent_t sb[$];
  logic [7:0] m_cnt [4];
  logic m_drop;
  vec_t vt [6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  function automatic int sidx(input logic [3:0] s);
    case (s)
      4'b0001: return 0;
      4'b1111: return 1;
      4'b0011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 8'h00;
    m_drop = 1'b0;
  endtask

  // one cycle of stimulus; pops are scored against the model
  task automatic drive(input logic v,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input logic rdy,
                       input logic clr);
    bit full;
    bit popm;
    int k;
    ent_t e;
    full = (sb.size() == DEPTH);
    popm = (sb.size() > 0) && rdy;
    if (popm) begin
      e = sb.pop_front();
      chk("pop_data", bus.data_out, e.data);
      chk("pop_status", {28'h0, bus.status_out},
          {28'h0, e.stat});
    end
    if (v && (!full || popm)) begin
      e.data = d;
      e.stat = s;
      sb.push_back(e);
    end
    k = sidx(s);
    if (clr) begin
      model_clear();
    end else if (v) begin
      if (k >= 0 && m_cnt[k] != 8'hFF) m_cnt[k]++;
      if (full && !popm) m_drop = 1'b1;
    end
    bus.res_valid_in  = v;
    bus.res_data_in   = d;
    bus.res_status_in = s;
    bus.ready_in      = rdy;
    clear_in          = clr;
    tick();
    bus.res_valid_in = 1'b0;
    bus.ready_in     = 1'b0;
    clear_in         = 1'b0;
  endtask

  task automatic do_reset(input logic v);
    reset              = 1'b1;
    bus.res_valid_in   = v;
    bus.res_data_in    = 32'hDEADBEEF;
    bus.res_status_in  = EXACT;
    tick();
    reset            = 1'b0;
    bus.res_valid_in = 1'b0;
    sb.delete();
    model_clear();
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_valid"}, {31'h0, bus.valid_out},
        {31'h0, sb.size() > 0});
    if (sb.size() > 0) begin
      chk({nm, "_head"}, bus.data_out, sb[0].data);
      chk({nm, "_hstat"}, {28'h0, bus.status_out},
          {28'h0, sb[0].stat});
    end else begin
      chk({nm, "_dec0"},
          {23'h0, bus.sign_out, bus.exp_out, bus.zero_out},
          32'h0);
    end
    chk({nm, "_cexact"}, {24'h0, cnt_exact},   {24'h0, m_cnt[0]});
    chk({nm, "_cinex"},  {24'h0, cnt_inexact}, {24'h0, m_cnt[1]});
    chk({nm, "_covf"},   {24'h0, cnt_ovf},     {24'h0, m_cnt[2]});
    chk({nm, "_cunf"},   {24'h0, cnt_unf},     {24'h0, m_cnt[3]});
    chk({nm, "_drop"},   {31'h0, drop_out},    {31'h0, m_drop});
  endtask

  initial begin
    vt[0] = '{32'h3E000000, 4'b0001, 1'b0, 7'h00, 1'b0};
    vt[1] = '{32'h80000000, 4'b0111, 1'b1, 7'h61, 1'b1};
    vt[2] = '{32'h7FFFFFFF, 4'b0011, 1'b0, 7'h20, 1'b0};
    vt[3] = '{32'h00000001, 4'b1111, 1'b0, 7'h61, 1'b0};
    vt[4] = '{32'hC2000000, 4'b0001, 1'b1, 7'h02, 1'b0};
    vt[5] = '{32'h01FFFFFF, 4'b0101, 1'b0, 7'h61, 1'b0};

    reset             = 1'b1;
    clear_in          = 1'b0;
    bus.res_valid_in  = 1'b0;
    bus.res_data_in   = '0;
    bus.res_status_in = '0;
    bus.ready_in      = 1'b0;
    model_clear();
    tick();
    do_reset(1'b0);

    chk("rst_valid", {31'h0, bus.valid_out}, 32'h0);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_status", {28'h0, bus.status_out}, 32'h0);
    check_state("rst");

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vt[i].data, vt[i].stat, 1'b0, 1'b0);
      check_state("vec_push");
      chk("vec_sign", {31'h0, bus.sign_out},
          {31'h0, vt[i].sgn});
      chk("vec_exp", {25'h0, bus.exp_out},
          {25'h0, vt[i].ex});
      chk("vec_zero", {31'h0, bus.zero_out},
          {31'h0, vt[i].zr});
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      check_state("vec_pop");
    end

    do_reset(1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'hA0000000 + i, INEXACT, 1'b0, 1'b0);
    check_state("fill");
    chk("fill_inexact5", {24'h0, cnt_inexact}, 32'd5);
    chk("fill_drop", {31'h0, drop_out}, 32'h1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_state("hold");

    drive(1'b1, 32'hB0000000, EXACT, 1'b1, 1'b0);
    check_state("full_pp");
    for (int i = 0; i < 4; i++) begin
      chk("full_pp_cnt", {31'h0, bus.valid_out}, 32'h1);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check_state("drain");
    chk("drain_empty", {31'h0, bus.valid_out}, 32'h0);

    do_reset(1'b0);
    for (int i = 0; i < 300; i++)
      drive(1'b1, 32'(i), OVERFLOW, 1'b1, 1'b0);
    check_state("sat");
    chk("sat_ovf255", {24'h0, cnt_ovf}, 32'd255);
    drive(1'b1, 32'h12345678, OVERFLOW, 1'b1, 1'b1);
    check_state("clr");
    chk("clr_ovf0", {24'h0, cnt_ovf}, 32'd0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    check_state("clr_drain");

    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'hC0000000 + i, UNDERFLOW, 1'b0, 1'b0);
    check_state("pre_rst");
    do_reset(1'b1);
    check_state("mid_rst");
    chk("mid_rst_valid", {31'h0, bus.valid_out}, 32'h0);
    chk("mid_rst_unf", {24'h0, cnt_unf}, 32'h0);
    drive(1'b1, 32'h3E000001, EXACT, 1'b0, 1'b0);
    check_state("post_rst");
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check_state("post_rst_pop");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_result_queue.md
FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, result queue depth in entries (power of two, >=2).
REQ-002 Parameter CNT_W, default 8, width of each status counter.
REQ-003 clock  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 res_data_in  input  32  FPU result word {sign[31], exp[30:25] biased by 31, mant[24:0]}.
REQ-006 res_status_in  input  4  FPU status: 0001 exact, 1111 inexact, 0011 overflow, 0111 underflow.
REQ-007 res_valid_in  input  1  one-cycle strobe per result; no backpressure to the producer.
REQ-008 ready_in  input  1  consumer accepts the head entry this cycle.
REQ-009 clear_in  input  1  clears all counters and the sticky drop flag.
REQ-010 valid_out  output  1  head entry is valid.
REQ-011 data_out  output  32  head result word, unmodified.
REQ-012 status_out  output  4  head status, unmodified.
REQ-013 sign_out  output  1  head sign bit.
REQ-014 exp_out  output  7  head unbiased exponent, signed: exp field minus 31.
REQ-015 zero_out  output  1  head exp field and mantissa both zero.
REQ-016 cnt_exact, cnt_inexact, cnt_ovf, cnt_unf  output  CNT_W each  per-status result counters.
REQ-017 drop_out  output  1  sticky: at least one result was lost because the queue was full.

Function
REQ-018 Occupancy state SHALL be EMPTY, PARTIAL or FULL, derived from a count register of width log2(DEPTH)+1.
REQ-019 Push SHALL occur when res_valid_in=1 and (state!=FULL, or state=FULL with a same-cycle pop).
REQ-020 Pop SHALL occur when valid_out=1 and ready_in=1.
REQ-021 Transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop at count DEPTH-1; FULL->PARTIAL on pop without push; PARTIAL->EMPTY on pop without push at count 1; simultaneous push and pop SHALL leave the count unchanged.
REQ-022 Outputs SHALL be first-word-fall-through: a push into EMPTY makes valid_out=1 and the head fields valid in the next cycle, which is 1-cycle latency.
REQ-023 sign_out, exp_out and zero_out SHALL be combinational decodes of the head entry and SHALL read as 0 when valid_out=0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 res_valid_in in state FULL without a pop SHALL discard the result and set drop_out on the next edge.
REQ-026 Each res_valid_in SHALL increment the counter matching res_status_in, including discarded results; unlisted codes SHALL be queued but not counted.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 clear_in SHALL zero all counters and drop_out; a clear coinciding with an increment SHALL win (result 0); clear_in SHALL NOT affect queue contents.
REQ-029 data_out and status_out SHALL hold their value while valid_out=1 and ready_in=0.

Reset
REQ-030 Reset SHALL force count, both pointers, all counters and drop_out to 0, and valid_out to 0; the data_out and status_out values SHALL read 0.
REQ-031 Reset asserted mid-operation SHALL discard every queued entry; a res_valid_in in the same cycle SHALL be ignored.
REQ-032 Storage array contents need not be reset.

Structure
REQ-033 A shared package fpu_pkg SHALL hold: the field widths (1/6/25), BIAS=31, and the status code constants EXACT, INEXACT, OVERFLOW, UNDERFLOW.
REQ-034 A single sub-module, fpu_result_decode (combinational word -> sign, unbiased exp, zero flag), SHALL be instantiated on the head entry.

Verification
REQ-035 One push of 0x3E000000 with status 0001 -> next cycle valid_out=1, exp_out=0, sign_out=0, zero_out=0, cnt_exact=1.
REQ-036 Five pushes of a status 1111 result with ready_in=0 and DEPTH=4 -> four entries queued, drop_out=1, cnt_inexact=5.
REQ-037 Queue FULL with a simultaneous push and pop -> count stays 4, the popped head is the oldest entry, and the new entry appears last in order.
REQ-038 Push 0x80000000 with status 0111 -> zero_out=1, sign_out=1, exp_out=-31, cnt_unf=1.
REQ-039 300 overflow-status pushes -> cnt_ovf=255; clear_in coinciding with one more push -> cnt_ovf=0.
REQ-040 Reset asserted with 3 entries queued and res_valid_in=1 -> next cycle valid_out=0, all counters 0, queue empty.
